// File: rtl/matmul_instr_seq.sv
//==============================================================================
// Module      : matmul_instr_seq
// Description : Counter-driven MIPS instruction generator for C = A x B over
//               NxN matrices. Optional macro MATMUL_SEQ_NOP_EN inserts a NOP
//               between each mul and the add that consumes it.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module matmul_instr_seq #(
    parameter int N      = 3,
    parameter int A_BASE = 0,
    parameter int B_BASE = 9,
    parameter int C_BASE = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ready,
    output logic [31:0] instr,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic [2:0]  row,
    output logic [2:0]  col
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LDA  = 3'd2,
        S_LDB  = 3'd3,
        S_MUL  = 3'd4,
        S_ADD  = 3'd5,
        S_STO  = 3'd6,
        S_NOP  = 3'd7
    } state_t;

    localparam logic [2:0]  c_last   = 3'(N - 1);
    localparam logic [15:0] c_n      = 16'(N);
    localparam logic [15:0] c_a_base = 16'(A_BASE);
    localparam logic [15:0] c_b_base = 16'(B_BASE);
    localparam logic [15:0] c_c_base = 16'(C_BASE);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_i, r_j, r_k;
    logic [2:0]  w_i_nxt, w_j_nxt, w_k_nxt;
    logic        w_fin;
    logic [31:0] w_instr_nxt;
    logic [15:0] w_i16, w_j16, w_k16;

    // Everything advances on acceptance only, so a stall holds state for free.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_fin       = 1'b0;
        if (r_state == S_IDLE) begin
            if (start) begin
                w_state_nxt = S_CLR;
                w_i_nxt     = 3'd0;
                w_j_nxt     = 3'd0;
                w_k_nxt     = 3'd0;
            end
        end else if (valid && ready) begin
            case (r_state)
                S_CLR: w_state_nxt = S_LDA;
                S_LDA: w_state_nxt = S_LDB;
                S_LDB: w_state_nxt = S_MUL;
`ifdef MATMUL_SEQ_NOP_EN
                S_MUL: w_state_nxt = S_NOP;
                S_NOP: w_state_nxt = S_ADD;
`else
                S_MUL: w_state_nxt = S_ADD;
`endif
                S_ADD: begin
                    if (r_k == c_last) begin
                        w_k_nxt     = 3'd0;
                        w_state_nxt = S_STO;
                    end else begin
                        w_k_nxt     = r_k + 3'd1;
                        w_state_nxt = S_LDA;
                    end
                end
                S_STO: begin
                    if (r_j != c_last) begin
                        w_j_nxt     = r_j + 3'd1;
                        w_state_nxt = S_CLR;
                    end else if (r_i != c_last) begin
                        w_j_nxt     = 3'd0;
                        w_i_nxt     = r_i + 3'd1;
                        w_state_nxt = S_CLR;
                    end else begin
                        w_i_nxt     = 3'd0;
                        w_j_nxt     = 3'd0;
                        w_state_nxt = S_IDLE;
                        w_fin       = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_i16 = {13'd0, w_i_nxt};
    assign w_j16 = {13'd0, w_j_nxt};
    assign w_k16 = {13'd0, w_k_nxt};

    // The word for the upcoming state is encoded here so instr is a plain flop.
    always_comb begin
        w_instr_nxt = 32'd0;
        case (w_state_nxt)
            S_CLR: w_instr_nxt = {6'b001000, 5'd23, 5'd19, 16'd0};
            S_LDA: w_instr_nxt = {6'b100011, 5'd23, 5'd16, 16'(c_a_base + w_i16 * c_n + w_k16)};
            S_LDB: w_instr_nxt = {6'b100011, 5'd23, 5'd17, 16'(c_b_base + w_k16 * c_n + w_j16)};
            S_MUL: w_instr_nxt = {6'b000000, 5'd16, 5'd17, 5'd18, 5'd0, 6'b011000};
            S_ADD: w_instr_nxt = {6'b000000, 5'd18, 5'd19, 5'd19, 5'd0, 6'b100000};
            S_STO: w_instr_nxt = {6'b101011, 5'd23, 5'd19, 16'(c_c_base + w_i16 * c_n + w_j16)};
            default: w_instr_nxt = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= 3'd0;
            r_j     <= 3'd0;
            r_k     <= 3'd0;
            instr   <= 32'd0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            row     <= 3'd0;
            col     <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            instr   <= w_instr_nxt;
            valid   <= (w_state_nxt != S_IDLE);
            busy    <= (w_state_nxt != S_IDLE);
            done    <= w_fin;
            row     <= w_i_nxt;
            col     <= w_j_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_matmul_instr_seq.sv
//==============================================================================
// Module      : tb_matmul_instr_seq
// Description : Scoreboard bench for matmul_instr_seq against a loop-based model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_matmul_instr_seq;

    localparam int N      = 3;
    localparam int A_BASE = 0;
    localparam int B_BASE = 9;
    localparam int C_BASE = 18;
`ifdef MATMUL_SEQ_NOP_EN
    localparam int PER_K  = 5;
`else
    localparam int PER_K  = 4;
`endif
    localparam int WORDS  = N * N * (PER_K * N + 2);
    localparam logic [31:0] c_clr = 32'h22F3_0000;

    logic        clk, rst, start, ready;
    logic [31:0] instr;
    logic        valid, busy, done;
    logic [2:0]  row, col;

    matmul_instr_seq #(.N(N), .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .instr (instr),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .row   (row),
        .col   (col)
    );

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    int          run_pos    = 0;
    int          acc_total  = 0;
    bit          exp_done   = 0;
    bit          hold_v     = 0;
    logic [31:0] hold_w     = 0;
    logic [31:0] last_word  = 0;
    bit          rand_ready = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference instruction stream, straight from the C = A x B loop nest.
    task automatic push_run();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                exp_q.push_back({6'b001000, 5'd23, 5'd19, 16'd0});
                for (int k = 0; k < N; k++) begin
                    exp_q.push_back({6'b100011, 5'd23, 5'd16, 16'(A_BASE + i * N + k)});
                    exp_q.push_back({6'b100011, 5'd23, 5'd17, 16'(B_BASE + k * N + j)});
                    exp_q.push_back(32'h0211_9018);
`ifdef MATMUL_SEQ_NOP_EN
                    exp_q.push_back(32'h0000_0000);
`endif
                    exp_q.push_back(32'h0253_9820);
                end
                exp_q.push_back({6'b101011, 5'd23, 5'd19, 16'(C_BASE + i * N + j)});
            end
    endtask

    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops on every acceptance; stall and done checks too.
    always @(negedge clk) begin
        check("done", {31'd0, done}, {31'd0, exp_done});
        exp_done = 0;
        if (rst) begin
            run_pos = 0;
            hold_v  = 0;
        end else begin
            if (hold_v) begin
                check("stall_valid", {31'd0, valid}, 32'd1);
                check("stall_instr", instr, hold_w);
            end
            hold_v = 0;
            if (valid && !ready) begin
                hold_v = 1;
                hold_w = instr;
            end
            if (valid && ready) begin
                acc_total++;
                last_word = instr;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_word: got %h expected none", instr);
                end else begin
                    check("word", instr, exp_q.pop_front());
                end
                run_pos++;
                if (run_pos == WORDS) begin
                    run_pos  = 0;
                    exp_done = 1;
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},  32'd0);
        check({tag, "_done"},  {31'd0, done},  32'd0);
        check({tag, "_row"},   {29'd0, row},   32'd0);
        check({tag, "_col"},   {29'd0, col},   32'd0);
    endtask

    task automatic start_run();
        push_run();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("latency_valid", {31'd0, valid}, 32'd1);
        check("latency_instr", instr, c_clr);
    endtask

    task automatic wait_done(input int a0, input int left, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!done && n < budget);
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end else begin
            check("run_words", 32'(acc_total - a0), 32'(WORDS));
            check("last_word", last_word, {6'b101011, 5'd23, 5'd19, 16'(C_BASE + N * N - 1)});
            check("queue_left", 32'(exp_q.size()), 32'(left));
            check("idle_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int a0;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Full run with ready high
        a0 = acc_total;
        start_run();
        wait_done(a0, 0, 4 * WORDS);

        // Random backpressure
        rand_ready = 1;
        a0 = acc_total;
        start_run();
        wait_done(a0, 0, 8 * WORDS);
        rand_ready = 0;

        // Abort at word 40
        start_run();
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (run_pos < 40 && n < 4 * WORDS);
        #1 rst = 1'b1;
        #1 check_outputs_zero("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        a0 = acc_total;
        start_run();
        wait_done(a0, 0, 4 * WORDS);

        // start held high through a run: no restart mid-run, restart after done
        push_run();
        push_run();
        @(posedge clk);
        #1 start = 1'b1;
        a0 = acc_total;
        wait_done(a0, WORDS, 4 * WORDS);
        @(posedge clk);
        #1 start = 1'b0;
        check("restart_valid", {31'd0, valid}, 32'd1);
        check("restart_instr", instr, c_clr);
        a0 = acc_total;
        wait_done(a0, 0, 4 * WORDS);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
